// File: rtl/lp805x_syncq.sv
// lp805x_syncq: single-clock queue with wput/wrdy and rget/rrdy handshakes,
// occupancy level, almost-full flag, synchronous flush and sticky error flags.
//
// Handshake semantics: a write transfers on a rising edge where wput=1 and
// wrdy=1; a read transfers on a rising edge where rget=1 and rrdy=1. wrdy and
// rrdy depend only on registered state, never on wput/rget, so a request may
// be held or dropped freely. A request made while its ready is low is not a
// transfer. It sets the matching sticky error flag (ovf/udf) unless flush is
// high in that cycle.
module lp805x_syncq #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int FWFT   = 1,
    parameter int AF_THR = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wput,
    output logic              wrdy,
    output logic [DATA_W-1:0] data_out,
    input  logic              rget,
    output logic              rrdy,
    input  logic              flush,
    output logic [AW:0]       level,
    output logic              afull,
    output logic              ovf,
    output logic              udf
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_THR);
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q,  level_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    // In FWFT mode this holds the last head word seen while non-empty; in
    // registered mode it is the read data register itself.
    logic [DATA_W-1:0] dout_q,   dout_d;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    // Status flags come straight from the registered level.
    assign wrdy  = (level_q != FULL_LVL);
    assign rrdy  = (level_q != '0);
    assign afull = (level_q >= AF_LVL);
    assign level = level_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

    assign head  = mem_q[rd_ptr_q];

    // Accepted transfers; flush masks both so nothing moves in a flush cycle.
    assign push = wput && wrdy && !flush;
    assign pop  = rget && rrdy && !flush;

    // Read data: combinational head in FWFT mode, registered otherwise.
    assign data_out = (FWFT != 0) ? (rrdy ? head : dout_q) : dout_q;

    // Next-state for pointers, level, error flags and read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        dout_d   = dout_q;

        if (FWFT != 0) begin
            if (rrdy) begin
                dout_d = head;
            end
        end else begin
            if (pop) begin
                dout_d = head;
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + ONE_LVL;
                2'b01:   level_d = level_q - ONE_LVL;
                default: level_d = level_q;
            endcase
            if (wput && !wrdy) begin
                ovf_d = 1'b1;
            end
            if (rget && !rrdy) begin
                udf_d = 1'b1;
            end
        end
    end

    // Control and read-data registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array; contents are never read before being written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_lp805x_syncq.sv
// Directed bench for lp805x_syncq: one FWFT instance and one registered-read
// instance sharing clock and reset.
module tb_lp805x_syncq;

    localparam int DATA_W = 40;
    localparam int AW     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // FWFT instance signals
    logic [DATA_W-1:0] a_din = '0;
    logic              a_wput = 1'b0;
    logic              a_rget = 1'b0;
    logic              a_flush = 1'b0;
    logic              a_wrdy, a_rrdy, a_afull, a_ovf, a_udf;
    logic [DATA_W-1:0] a_dout;
    logic [AW:0]       a_level;

    // Registered-read instance signals
    logic [DATA_W-1:0] b_din = '0;
    logic              b_wput = 1'b0;
    logic              b_rget = 1'b0;
    logic              b_flush = 1'b0;
    logic              b_wrdy, b_rrdy, b_afull, b_ovf, b_udf;
    logic [DATA_W-1:0] b_dout;
    logic [AW:0]       b_level;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    localparam logic [DATA_W-1:0] W1 = 40'h01_1111_1111;
    localparam logic [DATA_W-1:0] W2 = 40'h02_2222_2222;
    localparam logic [DATA_W-1:0] W3 = 40'h03_3333_3333;
    localparam logic [DATA_W-1:0] W4 = 40'h04_4444_4444;
    localparam logic [DATA_W-1:0] W5 = 40'h05_5555_5555;
    localparam logic [DATA_W-1:0] W6 = 40'h06_6666_6666;
    localparam logic [DATA_W-1:0] W9 = 40'h09_9999_9999;
    localparam logic [DATA_W-1:0] WA = 40'h0A_AAAA_AAAA;
    localparam logic [DATA_W-1:0] WF = 40'h0F_FFFF_FFFF;
    localparam logic [DATA_W-1:0] WG = 40'h1C_0FFE_E123;

    lp805x_syncq #(.DATA_W(DATA_W), .DEPTH(4), .AW(AW), .FWFT(1), .AF_THR(3)) u_fwft (
        .clk(clk), .rst(rst), .data_in(a_din), .wput(a_wput), .wrdy(a_wrdy),
        .data_out(a_dout), .rget(a_rget), .rrdy(a_rrdy), .flush(a_flush),
        .level(a_level), .afull(a_afull), .ovf(a_ovf), .udf(a_udf)
    );

    lp805x_syncq #(.DATA_W(DATA_W), .DEPTH(4), .AW(AW), .FWFT(0), .AF_THR(3)) u_reg (
        .clk(clk), .rst(rst), .data_in(b_din), .wput(b_wput), .wrdy(b_wrdy),
        .data_out(b_dout), .rget(b_rget), .rrdy(b_rrdy), .flush(b_flush),
        .level(b_level), .afull(b_afull), .ovf(b_ovf), .udf(b_udf)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_wrdy",  a_wrdy,  1);
        check("rst_rrdy",  a_rrdy,  0);
        check("rst_level", a_level, 0);
        check("rst_afull", a_afull, 0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_udf",   a_udf,   0);
        check("rst_dout",  a_dout,  0);
        check("rst_b_dout", b_dout, 0);
        rst = 1'b1;
        tick();
        check("idle_level", a_level, 0);
        check("idle_rrdy",  a_rrdy,  0);

        // Two pushes, two pops
        a_wput = 1'b1; a_din = 40'hAA55;
        tick();
        check("p1_level", a_level, 1);
        check("p1_rrdy",  a_rrdy,  1);
        check("p1_dout",  a_dout,  40'hAA55);
        a_din = 40'h88FFFF5500;
        tick();
        check("p2_level", a_level, 2);
        check("p2_dout",  a_dout,  40'hAA55);
        a_wput = 1'b0; a_rget = 1'b1;
        tick();
        check("g1_level", a_level, 1);
        check("g1_dout",  a_dout,  40'h88FFFF5500);
        tick();
        check("g2_level", a_level, 0);
        check("g2_rrdy",  a_rrdy,  0);
        a_rget = 1'b0;

        // Fill, overflow, drain, underflow
        a_wput = 1'b1;
        a_din = W1; tick();
        a_din = W2; tick();
        check("f2_afull", a_afull, 0);
        a_din = W3; tick();
        check("f3_level", a_level, 3);
        check("f3_afull", a_afull, 1);
        check("f3_wrdy",  a_wrdy,  1);
        a_din = W4; tick();
        check("f4_level", a_level, 4);
        check("f4_wrdy",  a_wrdy,  0);
        check("f4_ovf",   a_ovf,   0);
        a_din = W9; tick();
        check("ovf_set",   a_ovf,   1);
        check("ovf_level", a_level, 4);
        a_wput = 1'b0; a_rget = 1'b1;
        check("d_head1", a_dout, W1);
        tick();
        check("d_head2", a_dout, W2);
        tick();
        check("d_head3", a_dout, W3);
        tick();
        check("d_head4", a_dout, W4);
        tick();
        check("d_level0", a_level, 0);
        check("d_udf0",   a_udf,   0);
        tick();
        check("udf_set",   a_udf,   1);
        check("udf_level", a_level, 0);
        check("udf_ovf",   a_ovf,   1);
        a_rget = 1'b0; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("fl_ovf", a_ovf, 0);
        check("fl_udf", a_udf, 0);

        // Full queue with simultaneous push and pop
        a_wput = 1'b1;
        a_din = W5; tick();
        a_din = W6; tick();
        a_din = W3; tick();
        a_din = W4; tick();
        check("sf_level", a_level, 4);
        check("sf_head",  a_dout,  W5);
        a_din = W9; a_rget = 1'b1;
        tick();
        check("sf_level3", a_level, 3);
        check("sf_ovf",    a_ovf,   1);
        check("sf_head2",  a_dout,  W6);
        a_wput = 1'b0; a_rget = 1'b0; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("sf_flush_level", a_level, 0);

        // Empty queue with simultaneous push and pop
        a_wput = 1'b1; a_rget = 1'b1; a_din = WA;
        tick();
        a_wput = 1'b0; a_rget = 1'b0;
        check("se_level", a_level, 1);
        check("se_udf",   a_udf,   1);
        check("se_dout",  a_dout,  WA);

        // Flush at level 3 with ovf set, together with a write
        a_wput = 1'b1;
        a_din = W1; tick();
        a_din = W2; tick();
        a_din = W3; tick();
        a_din = W4; tick();
        check("pf_ovf", a_ovf, 1);
        a_wput = 1'b0; a_rget = 1'b1;
        tick();
        a_rget = 1'b0;
        check("pf_level3", a_level, 3);
        a_flush = 1'b1; a_wput = 1'b1; a_din = WF;
        tick();
        a_flush = 1'b0; a_wput = 1'b0;
        check("fw_level", a_level, 0);
        check("fw_ovf",   a_ovf,   0);
        check("fw_udf",   a_udf,   0);
        check("fw_rrdy",  a_rrdy,  0);
        a_wput = 1'b1; a_din = WG;
        tick();
        a_wput = 1'b0;
        check("fw_new_level", a_level, 1);
        check("fw_new_head",  a_dout,  WG);

        // Registered-read mode
        b_wput = 1'b1; b_din = 40'h1234;
        tick();
        b_wput = 1'b0;
        check("r_level1", b_level, 1);
        check("r_dout_pre", b_dout, 0);
        b_rget = 1'b1;
        tick();
        b_rget = 1'b0;
        check("r_dout", b_dout, 40'h1234);
        check("r_rrdy", b_rrdy, 0);
        tick();
        check("r_hold", b_dout, 40'h1234);
        b_wput = 1'b1; b_din = 40'h5678;
        tick();
        b_wput = 1'b0; b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        check("r_fl_level", b_level, 0);
        check("r_fl_dout",  b_dout,  40'h1234);

        // Asynchronous reset in the middle of a push
        a_wput = 1'b1; a_din = W2;
        tick();
        check("ar_level_pre", a_level, 2);
        #3 rst = 1'b0;
        #1;
        check("ar_level", a_level, 0);
        check("ar_rrdy",  a_rrdy,  0);
        check("ar_wrdy",  a_wrdy,  1);
        check("ar_afull", a_afull, 0);
        check("ar_dout",  a_dout,  0);
        check("ar_b_dout", b_dout, 0);
        a_wput = 1'b0;
        #10 rst = 1'b1;
        tick();
        check("ar_post_level", a_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
